// File: rtl/data_mem_responder_pkg.sv
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared encodings for the data memory responder: access size,
//               load extension, FSM states, byte-lane masks and the lane-mask
//               helper. Optional build macro used by the top:
//               MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_responder_pkg;

  // Access size, matching the CPU memDataSize encoding
  localparam logic [1:0] MEM_SIZE_WORD = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd2;
  localparam logic [1:0] MEM_SIZE_INV  = 2'd3;

  // Load extension, matching the CPU memBitExtend encoding
  localparam logic MEM_EXT_SIGN = 1'b0;
  localparam logic MEM_EXT_ZERO = 1'b1;

  // Byte-lane masks (bit i enables bits [8i+7:8i])
  localparam logic [3:0] LANE_NONE    = 4'b0000;
  localparam logic [3:0] LANE_ALL     = 4'b1111;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Lanes touched by an access of the given size at an (already aligned) offset
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    m = LANE_NONE;
    case (size)
      MEM_SIZE_WORD: m = LANE_ALL;
      MEM_SIZE_HALF: m = off[1] ? LANE_HALF_HI : LANE_HALF_LO;
      MEM_SIZE_BYTE: m = LANE_BYTE0 << off;
      default:       m = LANE_NONE;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_load_formatter.sv
// ============================================================================
// Module      : data_mem_responder_load_formatter
// Description : Combinational load formatter. Selects the addressed lane(s)
//               of a RAM word and sign- or zero-extends them to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder_load_formatter
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  // Pick the addressed lane(s), then extend according to size and zext
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    fill     = 1'b0;
    data_o   = 32'd0;
    case (size_i)
      MEM_SIZE_WORD: data_o = rdata_i;
      MEM_SIZE_HALF: begin
        fill   = (zext_i == MEM_EXT_SIGN) & half_sel[15];
        data_o = {{16{fill}}, half_sel};
      end
      MEM_SIZE_BYTE: begin
        fill   = (zext_i == MEM_EXT_SIGN) & byte_sel[7];
        data_o = {{24{fill}}, byte_sel};
      end
      default: data_o = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : One-at-a-time load/store responder in front of a synchronous
//               single-port word RAM with byte-lane write enables.
//               Build macro MEM_MISALIGN_TRAP_EN: when defined, misaligned
//               half/word requests are errors; otherwise the offending low
//               address bits are cleared and the access proceeds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_zext,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [3:0]        mask_q,  mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q,  size_d;
  logic [1:0]        off_q,   off_d;
  logic              zext_q,  zext_d;
  logic              write_q, write_d;
  logic              err_q,   err_d;

  logic        new_err;
  logic [1:0]  new_off;
  logic [31:0] fmt_data;

  // Address bits above the RAM index are intentionally ignored
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Classify an incoming request and derive its effective lane offset
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    new_off = req_addr[1:0];
    new_err = (req_size == MEM_SIZE_INV) ||
              ((req_size == MEM_SIZE_HALF) && req_addr[0]) ||
              ((req_size == MEM_SIZE_WORD) && (req_addr[1:0] != 2'd0));
`else
    new_err = (req_size == MEM_SIZE_INV);
    case (req_size)
      MEM_SIZE_WORD: new_off = 2'd0;
      MEM_SIZE_HALF: new_off = {req_addr[1], 1'b0};
      default:       new_off = req_addr[1:0];
    endcase
`endif
  end

  // Capture the request when it is accepted in IDLE, otherwise hold
  always_comb begin
    idx_d   = idx_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    zext_d  = zext_q;
    write_d = write_q;
    err_d   = err_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      idx_d   = req_addr[ADDR_W+1:2];
      size_d  = req_size;
      off_d   = new_off;
      zext_d  = req_zext;
      write_d = req_write;
      err_d   = new_err;
      mask_d  = (req_write && !new_err) ? lane_mask(req_size, new_off) : LANE_NONE;
      wdata_d = 32'd0;
      if (req_write) begin
        case (req_size)
          MEM_SIZE_BYTE: wdata_d = {4{req_wdata[7:0]}};
          MEM_SIZE_HALF: wdata_d = {2{req_wdata[15:0]}};
          default:       wdata_d = req_wdata;
        endcase
      end
    end
  end

  // Request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      mask_q  <= LANE_NONE;
      wdata_q <= 32'd0;
      size_q  <= MEM_SIZE_WORD;
      off_q   <= 2'd0;
      zext_q  <= MEM_EXT_SIGN;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      zext_q  <= zext_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: errors skip the RAM access entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = new_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  data_mem_responder_load_formatter u_fmt (
    .rdata_i (ram_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .zext_i  (zext_q),
    .data_o  (fmt_data)
  );

  // FSM outputs: everything idles at zero outside its active state
  always_comb begin
    req_ready  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = LANE_NONE;
    ram_addr   = '0;
    ram_wdata  = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = mask_q;
        ram_addr  = idx_q;
        ram_wdata = wdata_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!write_q && !err_q) resp_rdata = fmt_data;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder with a
//               behavioural byte-enabled synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_zext;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0]        req_size;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  // backdoor preload port into the RAM model
  logic              bd_en;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0]       bd_data;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  // captured transaction results
  logic [31:0] t_rdata, t_wd;
  logic        t_err, t_en, t_seen;
  logic [3:0]  t_we;
  int          t_lat;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_zext   (req_zext),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // synchronous RAM, read-before-write, with backdoor preload
  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // issue one request and record what happens until the response strobe
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] size, input logic zext);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd; req_size = size; req_zext = zext;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t_lat = 0; t_en = 1'b0; t_we = 4'h0; t_wd = 32'h0; t_seen = 1'b0;
    t_rdata = 32'hx; t_err = 1'bx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t_lat++;
      if (ram_en) begin
        t_en = 1'b1; t_we = ram_we; t_wd = ram_wdata;
      end
      if (resp_valid) begin
        t_seen = 1'b1; t_rdata = resp_rdata; t_err = resp_err;
        break;
      end
    end
    check_eq("resp_seen", {31'd0, t_seen}, 32'd1);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic zext, input logic [31:0] exp);
    txn(1'b0, addr, 32'h0, size, zext);
    check_eq(tag, t_rdata, exp);
    check_eq({tag, "_err"}, {31'd0, t_err}, 32'd0);
    check_eq({tag, "_lat"}, t_lat, 32'd2);
  endtask

  int first_acc, second_acc, resp_cnt;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_size = 2'd0; req_zext = 1'b0;
    bd_en = 1'b0; bd_addr = '0; bd_data = 32'h0;

    preload(10'd0, 32'h8081_7F80);
    preload(10'd1, 32'hCAFE_1234);
    preload(10'd4, 32'h1122_3344);

    // reset state
    #1;
    check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst_rerr", {31'd0, resp_err}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_en", {31'd0, ram_en}, 32'd0);
    check_eq("rst_we", {28'd0, ram_we}, 32'd0);
    check_eq("rst_addr", {22'd0, ram_addr}, 32'd0);
    check_eq("rst_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // loads: byte and half with both extensions, word, upper address bits ignored
    load_chk("ld_b1_s", 32'h1, 2'd2, 1'b0, 32'h0000_007F);
    load_chk("ld_b3_s", 32'h3, 2'd2, 1'b0, 32'hFFFF_FF80);
    load_chk("ld_b0_z", 32'h0, 2'd2, 1'b1, 32'h0000_0080);
    load_chk("ld_h2_z", 32'h2, 2'd1, 1'b1, 32'h0000_8081);
    load_chk("ld_h2_s", 32'h2, 2'd1, 1'b0, 32'hFFFF_8081);
    load_chk("ld_h0_s", 32'h0, 2'd1, 1'b0, 32'h0000_7F80);
    load_chk("ld_w0", 32'h0, 2'd0, 1'b0, 32'h8081_7F80);
    load_chk("ld_hiaddr", 32'h1000, 2'd0, 1'b0, 32'h8081_7F80);

    // half store into upper lanes
    txn(1'b1, 32'h12, 32'h0000_BEEF, 2'd1, 1'b0);
    check_eq("st_h_we", {28'd0, t_we}, 32'hC);
    check_eq("st_h_wd", t_wd, 32'hBEEF_BEEF);
    check_eq("st_h_lat", t_lat, 32'd2);
    check_eq("st_h_err", {31'd0, t_err}, 32'd0);
    check_eq("st_h_rdata", t_rdata, 32'd0);
    check_eq("st_h_mem", mem[4], 32'hBEEF_3344);

    // byte store into lane 1, then read the word back through the DUT
    txn(1'b1, 32'h5, 32'h1234_56AB, 2'd2, 1'b0);
    check_eq("st_b_we", {28'd0, t_we}, 32'h2);
    check_eq("st_b_wd", t_wd, 32'hABAB_ABAB);
    load_chk("ld_after_st", 32'h4, 2'd0, 1'b0, 32'hCAFE_AB34);

    // invalid size: error one cycle after acceptance, no RAM access
    txn(1'b0, 32'h0, 32'h0, 2'd3, 1'b0);
    check_eq("inv_err", {31'd0, t_err}, 32'd1);
    check_eq("inv_lat", t_lat, 32'd1);
    check_eq("inv_en", {31'd0, t_en}, 32'd0);
    check_eq("inv_rdata", t_rdata, 32'd0);

    // invalid-size store must not write
    txn(1'b1, 32'h10, 32'hFFFF_FFFF, 2'd3, 1'b0);
    check_eq("inv_st_en", {31'd0, t_en}, 32'd0);
    check_eq("inv_st_mem", mem[4], 32'hBEEF_3344);

    // misaligned accesses
    txn(1'b0, 32'h6, 32'h0, 2'd0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq("mis_w_err", {31'd0, t_err}, 32'd1);
    check_eq("mis_w_en", {31'd0, t_en}, 32'd0);
    check_eq("mis_w_lat", t_lat, 32'd1);
    txn(1'b0, 32'h3, 32'h0, 2'd1, 1'b0);
    check_eq("mis_h_err", {31'd0, t_err}, 32'd1);
`else
    check_eq("mis_w_err", {31'd0, t_err}, 32'd0);
    check_eq("mis_w_data", t_rdata, 32'hCAFE_AB34);
    load_chk("mis_h", 32'h3, 2'd1, 1'b0, 32'hFFFF_8081);
`endif

    // back-to-back: valid held high, second accept three cycles later
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_zext = 1'b0;
    first_acc = -1; second_acc = -1; resp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (req_ready) begin
        if (first_acc < 0) first_acc = i;
        else begin
          second_acc = i;
          break;
        end
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check_eq("b2b_first", first_acc, 32'd0);
    check_eq("b2b_second", second_acc, 32'd3);
    check_eq("b2b_resps", resp_cnt, 32'd2);

    // reset during ACCESS of a store aborts it
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
    req_wdata = 32'hDEAD_BEEF; req_size = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_pre_we", {28'd0, ram_we}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_we", {28'd0, ram_we}, 32'd0);
    check_eq("abort_en", {31'd0, ram_en}, 32'd0);
    check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
    resp_cnt = 0;
    @(negedge clk);
    if (resp_valid) resp_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check_eq("abort_resp", resp_cnt, 32'd0);
    check_eq("abort_mem", mem[0], 32'h8081_7F80);
    load_chk("post_abort", 32'h0, 2'd0, 1'b0, 32'h8081_7F80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU load/store control outputs: memRead/memWrite, memDataSize (0=word, 1=half, 2=byte) and memBitExtend (0=sign, 1=zero).
- Accepts one request at a time and drives a synchronous single-port word-wide RAM with byte-lane write enables.
- For loads, returns lane-aligned, sign- or zero-extended data; for stores, returns an acknowledge.
- Sits between the CPU data path and the data RAM.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM index is req_addr[ADDR_W+1:2]; upper address bits are ignored.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  0=word, 1=half, 2=byte, 3=invalid
- req_zext  in  1  load extension: 0=sign, 1=zero
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  error flag, qualified by resp_valid
- ram_en  out  1  RAM access enable
- ram_we  out  4  byte-lane write enables; bit i = bits [8i+7:8i]
- ram_addr  out  ADDR_W  RAM word index
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Reset mid-operation aborts the transaction. ram_we drops immediately, so no write commits; no response is issued.
- Little-endian lanes.
  - Byte: lane = addr[1:0].
  - Half: lanes {1,0} if addr[1]=0, otherwise {3,2}.
  - Word: all lanes.
- Store data replication: byte stores use {4{wdata[7:0]}}, half stores use {2{wdata[15:0]}}, word stores use wdata.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, register the request (cycle A).
    - Valid request: go to ACCESS.
    - Error request: go directly to RESP with err=1.
  - ACCESS (A+1): ram_en=1; ram_addr=registered index; ram_we=lane mask if store, else 0. Next state: RESP.
  - RESP (A+2): resp_valid=1 for exactly one cycle.
    - Load: resp_rdata = selected lane(s) of ram_rdata, extended to 32 bits per req_zext.
    - Store or error: resp_rdata=0.
    - Next state: IDLE.
- Latency: response at A+2 (A+1 for errors). Throughput: one request per 3 cycles (2 for errors).
- req_valid asserted outside IDLE is ignored and not queued. The requester holds the request until it sees req_ready.
- req_size=3: always an error; no RAM access.
- Outputs other than the resp_* signals are 0 whenever they are not active in the current state.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned request is an error with no RAM access and no write. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Not defined: misalignment is never an error. Offending low address bits are forced to zero: half ignores addr[0], word ignores addr[1:0]. The access then proceeds normally.

Decomposition:
- Shared package/defines:
  - size encodings MEM_SIZE_WORD/HALF/BYTE, matching the memDataSize values;
  - extension encodings for sign/zero;
  - FSM state encodings;
  - lane-mask constants.
- Sub-module load_formatter (combinational): takes ram_rdata, addr[1:0], size, zext and produces the 32-bit extended result. It is shared with any future load path.

Test Plan:
- Byte load, sign extend: RAM[0]=0x8081_7F80; load byte addr 0x1, zext=0 -> resp_rdata=0x0000_007F. Load byte addr 0x3, zext=0 -> 0xFFFF_FF80.
- Half load, zero vs sign extend: RAM[0]=0x8081_7F80; load half addr 0x2 zext=1 -> 0x0000_8081; same with zext=0 -> 0xFFFF_8081.
- Half store lane: RAM[4]=0x1122_3344; store half 0xBEEF to addr 0x12 -> ram_we=4'b1100, RAM[4]=0xBEEF_3344, resp_valid at A+2 with resp_err=0.
- Byte store lane: store byte 0xAB to addr 0x5 -> ram_we=4'b0010, ram_wdata=0xABAB_ABAB.
- Invalid size and misalignment:
  - req_size=3 -> resp_err=1 at A+1, ram_en never asserted.
  - Word load from addr 0x6 with MEM_MISALIGN_TRAP_EN -> resp_err=1.
  - Same load without the macro -> returns RAM[1], resp_err=0.
- Back-to-back and reset abort:
  - req_valid held high for two loads -> second accepted only at IDLE, 3 cycles after the first.
  - rst_n pulsed low during ACCESS of a store -> RAM unchanged, no resp_valid, req_ready=1 immediately.
